// File: rtl/mod_counter_pkg.sv
// Shared encodings for mod_counter: counting modes and ONESHOT FSM states.
package mod_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mod_counter.sv
// Up/down modulo counter with 0..limit range, WRAP/SAT/ONESHOT terminal behaviour,
// synchronous load and a registered terminal-count pulse.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    mode_e            mode_q;
    state_e           state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             oneshot;
    logic             step;
    logic             at_term;

    assign mode_q  = mode_e'(mode);
    assign oneshot = (mode_q == MODE_ONESHOT);
    // Up-count treats anything at or above limit as terminal so loaded
    // out-of-range values fold back into 0..limit on the next step.
    assign at_term = dir ? (count == '0) : (count >= limit);
    assign step    = oneshot ? (en && (state == RUN)) : en;

    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        state_nxt = state;

        if (load) begin
            count_nxt = load_val;
        end else if (step) begin
            if (!at_term) begin
                count_nxt = dir ? (count - WIDTH'(1)) : (count + WIDTH'(1));
            end else begin
                tc_nxt = 1'b1;
                case (mode_q)
                    MODE_SAT:     count_nxt = dir ? '0 : limit;
                    MODE_ONESHOT: count_nxt = count;
                    default:      count_nxt = dir ? limit : '0;
                endcase
            end
        end

        if (!oneshot) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_nxt = RUN;
                RUN:        if (!load && step && at_term) state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            state <= IDLE;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            state <= state_nxt;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter (WIDTH=4): stimulus pushes hand-computed
// expectations, a monitor pops one per clock and compares.
module tb_mod_counter;

    localparam int unsigned W = 4;

    logic         clock = 1'b0;
    logic         rst   = 1'b1;
    logic         en    = 1'b0;
    logic         dir   = 1'b0;
    logic [1:0]   mode  = 2'b00;
    logic [W-1:0] limit = '0;
    logic         load  = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;

    typedef struct {
        logic [W-1:0] c;
        logic         t;
        logic         b;
        string        name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    mod_counter #(.WIDTH(W)) dut (
        .clock    (clock),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .limit    (limit),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .count    (count),
        .tc       (tc),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [W-1:0] ec, input logic et, input logic eb);
        checks++;
        if (count === ec && tc === et && busy === eb) begin
            passes++;
        end else begin
            $display("FAIL %s: got count=%0d tc=%0b busy=%0b, expected count=%0d tc=%0b busy=%0b",
                     nm, count, tc, busy, ec, et, eb);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and queue the outputs
    // expected after the following rising edge.
    task automatic cyc(input logic r, input logic ld, input logic [W-1:0] lv,
                       input logic e, input logic d, input logic [1:0] m,
                       input logic [W-1:0] lim, input logic s,
                       input logic [W-1:0] ec, input logic et, input logic eb,
                       input string nm);
        exp_t x;
        @(negedge clock);
        rst = r; load = ld; load_val = lv; en = e; dir = d;
        mode = m; limit = lim; start = s;
        x.c = ec; x.t = et; x.b = eb; x.name = nm;
        q.push_back(x);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check(x.name, x.c, x.t, x.b);
            end
        end
    end

    initial begin
        #1;
        check("reset_state", 4'd0, 1'b0, 1'b0);

        // WRAP up, limit 5
        cyc(0,0,0, 1,0,2'd0,5,0,  1,0,0, "wrap_up1");
        cyc(0,0,0, 1,0,2'd0,5,0,  2,0,0, "wrap_up2");
        cyc(0,0,0, 1,0,2'd0,5,0,  3,0,0, "wrap_up3");
        cyc(0,0,0, 1,0,2'd0,5,0,  4,0,0, "wrap_up4");
        cyc(0,0,0, 1,0,2'd0,5,0,  5,0,0, "wrap_up5");
        cyc(0,0,0, 1,0,2'd0,5,0,  0,1,0, "wrap_term");
        cyc(0,0,0, 1,0,2'd0,5,0,  1,0,0, "wrap_after");

        // SAT down from a loaded 2
        cyc(0,1,2, 1,1,2'd1,5,0,  2,0,0, "sat_load_en");
        cyc(0,0,0, 1,1,2'd1,5,0,  1,0,0, "sat_dn1");
        cyc(0,0,0, 1,1,2'd1,5,0,  0,0,0, "sat_dn0");
        cyc(0,0,0, 1,1,2'd1,5,0,  0,1,0, "sat_floor1");
        cyc(0,0,0, 1,1,2'd1,5,0,  0,1,0, "sat_floor2");
        cyc(0,0,0, 0,1,2'd1,5,0,  0,0,0, "sat_hold");

        // ONESHOT down from 3
        cyc(0,1,3, 0,1,2'd2,5,0,  3,0,0, "os_load");
        cyc(0,0,0, 1,1,2'd2,5,0,  3,0,0, "os_idle_en");
        cyc(0,0,0, 1,1,2'd2,5,1,  3,0,1, "os_start");
        cyc(0,0,0, 1,1,2'd2,5,0,  2,0,1, "os_dn2");
        cyc(0,0,0, 1,1,2'd2,5,1,  1,0,1, "os_start_in_run");
        cyc(0,0,0, 1,1,2'd2,5,0,  0,0,1, "os_dn0");
        cyc(0,0,0, 1,1,2'd2,5,0,  0,1,0, "os_term");
        cyc(0,0,0, 1,1,2'd2,5,0,  0,0,0, "os_done_hold");
        cyc(0,0,0, 1,0,2'd2,5,1,  0,0,1, "os_restart");
        cyc(0,0,0, 1,0,2'd2,5,0,  1,0,1, "os_up");
        cyc(0,0,0, 0,0,2'd0,5,0,  1,0,0, "os_mode_exit");

        // WRAP with out-of-range load, limit 9
        cyc(0,1,12, 1,0,2'd0,9,0, 12,0,0, "wrap_load12");
        cyc(0,0,0,  1,0,2'd0,9,0,  0,1,0, "wrap_above_lim");
        cyc(0,1,12, 1,1,2'd0,9,0, 12,0,0, "wrap_load12_dn");
        cyc(0,0,0,  1,1,2'd0,9,0, 11,0,0, "wrap_dn11");
        cyc(0,0,0,  1,1,2'd0,9,0, 10,0,0, "wrap_dn10");
        cyc(0,0,0,  1,1,2'd0,9,0,  9,0,0, "wrap_dn9");

        // reserved mode behaves as WRAP and ignores start
        cyc(0,1,0, 0,1,2'd3,9,0,  0,0,0, "rsvd_load0");
        cyc(0,0,0, 1,1,2'd3,9,0,  9,1,0, "rsvd_wrap");
        cyc(0,0,0, 0,1,2'd3,9,1,  9,0,0, "rsvd_start_ign");

        // limit 0: every enabled step is terminal
        cyc(0,1,0, 0,0,2'd0,0,0,  0,0,0, "lim0_load");
        cyc(0,0,0, 1,0,2'd0,0,0,  0,1,0, "lim0_up");
        cyc(0,0,0, 1,1,2'd0,0,0,  0,1,0, "lim0_down");

        // full-range limit 15
        cyc(0,1,14, 0,0,2'd0,15,0, 14,0,0, "max_load14");
        cyc(0,0,0,  1,0,2'd0,15,0, 15,0,0, "max_up15");
        cyc(0,0,0,  1,0,2'd0,15,0,  0,1,0, "max_wrap");
        cyc(0,1,15, 0,0,2'd1,15,0, 15,0,0, "sat_load15");
        cyc(0,0,0,  1,0,2'd1,15,0, 15,1,0, "sat_ceiling");

        // ONESHOT armed at 7, then asynchronous reset between edges
        cyc(0,1,7, 0,0,2'd2,5,0,  7,0,0, "os_load7");
        cyc(0,0,0, 0,1,2'd2,5,1,  7,0,1, "os_arm7");
        @(posedge clock);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 4'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        cyc(0,0,0, 1,0,2'd2,5,0,  0,0,0, "post_rst_idle");
        cyc(0,0,0, 1,0,2'd2,5,1,  0,0,1, "post_rst_start");
        cyc(0,0,0, 1,0,2'd2,5,0,  1,0,1, "run_up1");
        cyc(0,0,0, 1,0,2'd2,5,0,  2,0,1, "run_up2");
        cyc(0,0,0, 1,0,2'd2,5,0,  3,0,1, "run_up3");
        cyc(0,0,0, 1,0,2'd2,5,0,  4,0,1, "run_up4");

        // load beats step, keeps RUN; then terminal from above limit
        cyc(0,1,9, 1,0,2'd2,5,0,  9,0,1, "load_over_en");
        cyc(0,0,0, 1,0,2'd2,5,0,  9,1,0, "os_term_above");
        cyc(0,1,2, 0,0,2'd2,5,1,  2,0,1, "load_start");
        cyc(0,0,0, 1,0,2'd2,5,0,  3,0,1, "run_up_after");

        // reset held across an edge dominates load/step/start
        cyc(1,1,5, 1,0,2'd0,9,1,  0,0,0, "rst_priority");
        cyc(0,0,0, 0,0,2'd0,9,0,  0,0,0, "rst_release");

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clock);
        #2;
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter: WIDTH, default 8, counter width in bits (legal range 2..32).
REQ-002 Port: clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: en  in  1  step enable; one step per enabled cycle.
REQ-005 Port: dir  in  1  0 = count up, 1 = count down.
REQ-006 Port: mode  in  2  00 = WRAP, 01 = SAT, 10 = ONESHOT, 11 = reserved (treated as WRAP).
REQ-007 Port: limit  in  WIDTH  upper terminal value; counting range is 0..limit.
REQ-008 Port: load  in  1  synchronous load strobe.
REQ-009 Port: load_val  in  WIDTH  value written on load.
REQ-010 Port: start  in  1  ONESHOT arm strobe.
REQ-011 Port: count  out  WIDTH  registered counter value.
REQ-012 Port: tc  out  1  registered terminal-count pulse.
REQ-013 Port: busy  out  1  registered; high while the ONESHOT FSM is in RUN.

Function
REQ-014 The terminal value is limit when dir=0 and 0 when dir=1.
REQ-015 Per cycle, priority: load > enabled step > hold.
REQ-016 A load writes load_val to count unmodified, even when load_val > limit; the FSM state is unchanged; tc=0 on the next cycle.
REQ-017 An enabled up-step with count < limit produces count+1; an enabled down-step with count > 0 produces count-1.
REQ-018 An enabled up-step with count >= limit is a terminal event: WRAP -> 0, SAT -> limit, ONESHOT -> hold.
REQ-019 An enabled down-step with count == 0 is a terminal event: WRAP -> limit, SAT -> 0, ONESHOT -> hold.
REQ-020 tc is high for exactly the one cycle following each terminal event, and low otherwise.
REQ-021 In SAT mode, tc pulses on every enabled cycle spent at the terminal value.
REQ-022 A change of dir takes effect on the same cycle's step, with no dead cycle.
REQ-023 All arithmetic is modulo 2^WIDTH and is never reached outside 0..limit except via load; limit=0 makes every enabled step a terminal event.
REQ-024 In ONESHOT, the FSM has three states: IDLE, RUN, DONE.
REQ-025 ONESHOT FSM, IDLE or DONE: start=1 -> RUN; count is unchanged by the transition.
REQ-026 ONESHOT FSM, RUN: steps occur only here, and a terminal event -> DONE.
REQ-027 ONESHOT FSM, DONE: count holds until start or load.
REQ-028 ONESHOT: in IDLE and DONE, en is ignored; start in RUN is ignored; start together with load performs the load and the transition.
REQ-029 In WRAP, SAT and reserved modes, the FSM is forced to IDLE, busy=0, start is ignored, and stepping is governed by en alone.
REQ-030 A mode change while in RUN or DONE returns the FSM to IDLE on the next edge; count is preserved.
REQ-031 Output latency is one cycle from inputs to count, tc and busy; there are no combinational input-to-output paths.

Reset
REQ-032 rst=1 forces count=0, tc=0, busy=0 and FSM=IDLE immediately, independent of clock.
REQ-033 Reset asserted mid-count or mid-RUN discards all state; the first step after deassertion starts from 0.
REQ-034 Reset has priority over load, step and start.

Structure
REQ-035 Package mod_counter_pkg holds the mode encodings (WRAP, SAT, ONESHOT) and the FSM state enumeration (IDLE, RUN, DONE).
REQ-036 The block is a single module with no sub-modules; next-value and terminal-detect logic are inline.

Verification (WIDTH=4)
REQ-037 WRAP, dir=0, limit=5, en=1 from reset -> count 0,1,2,3,4,5,0,1; tc high only in the cycle count shows the first 0 after 5.
REQ-038 SAT, dir=1, load_val=2 then en=1 for 5 cycles -> count 2,1,0,0,0; tc high on each of the last two cycles.
REQ-039 ONESHOT, load_val=3, start, dir=1, en=1 -> busy=1, count 3,2,1,0; the next cycle gives tc=1, busy=0, FSM=DONE, count held at 0 despite en=1.
REQ-040 WRAP, limit=9, load_val=12, dir=0, en=1 -> count 12 then 0 with tc pulse; the same setup with dir=1 -> 12,11,10,9.
REQ-041 rst pulsed asynchronously mid-RUN at count=7 -> count=0, busy=0 without a clock edge; start is then needed to resume stepping.
REQ-042 load and en asserted together at count=4 with load_val=9 -> count=9 and tc=0; the ONESHOT state is unchanged.
